hazard_unit_mc: RTL and testbench



---
 rtl/hazard_pkg.sv | 22 ++
 rtl/hazard_unit_mc_stall_seq.sv | 112 +++++++++++
 rtl/hazard_unit_mc.sv | 136 +++++++++++++
 tb/tb_hazard_unit_mc.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the multi-cycle hazard unit: forwarding select
// encodings, stall sequencer states and the counter-width helper.
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        SEQ_IDLE     = 2'b00,
        SEQ_MEM_WAIT = 2'b01,
        SEQ_MUL_BUSY = 2'b10
    } seq_state_t;

    // Width of the sequencer down-counters: enough to hold the larger latency.
    function automatic int seq_cnt_w(input int mul_lat, input int mem_lat);
        int m;
        m = (mul_lat > mem_lat) ? mul_lat : mem_lat;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/hazard_unit_mc_stall_seq.sv
// Stall sequencer: holds the pipeline for the extra cycles of a multi-cycle
// data-memory access or execute operation. Entry is decided combinationally
// in the request cycle; the remaining cycles come from the registered state.
// A one-cycle release flag after each sequence stops the still-present
// request from retriggering.
module stall_seq
    import hazard_pkg::*;
#(
    parameter int MUL_LAT = 3,
    parameter int MEM_LAT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic mem_req,
    input  logic mul_req,
    output logic mem_busy,
    output logic mul_busy
);

    localparam int CW = seq_cnt_w(MUL_LAT, MEM_LAT);
    localparam logic MEM_EN   = (MEM_LAT > 1);
    localparam logic MUL_EN   = (MUL_LAT > 1);
    localparam logic MEM_LONG = (MEM_LAT > 2);
    localparam logic MUL_LONG = (MUL_LAT > 2);
    // Stalled cycles still owed after the entry cycle.
    localparam logic [CW-1:0] MEM_LOAD = MEM_LONG ? CW'(MEM_LAT - 2) : {CW{1'b0}};
    localparam logic [CW-1:0] MUL_LOAD = MUL_LONG ? CW'(MUL_LAT - 2) : {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    seq_state_t    state_r;
    logic [CW-1:0] mcnt_r;
    logic [CW-1:0] xcnt_r;
    logic          mem_rel_r;
    logic          mul_rel_r;
    logic          mem_start_s;
    logic          mul_start_s;

    // Entry decision in IDLE; memory wait has priority over multiply.
    always_comb begin
        mem_start_s = 1'b0;
        mul_start_s = 1'b0;
        if (reset && (state_r == SEQ_IDLE)) begin
            mem_start_s = mem_req & MEM_EN & ~mem_rel_r;
            mul_start_s = mul_req & MUL_EN & ~mul_rel_r & ~mem_start_s;
        end else begin
            mem_start_s = 1'b0;
            mul_start_s = 1'b0;
        end
    end

    assign mem_busy = mem_start_s | (reset & (state_r == SEQ_MEM_WAIT));
    assign mul_busy = mul_start_s | (reset & (state_r == SEQ_MUL_BUSY));

    // Sequencer state, down-counters and one-cycle release flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= SEQ_IDLE;
            mcnt_r    <= {CW{1'b0}};
            xcnt_r    <= {CW{1'b0}};
            mem_rel_r <= 1'b0;
            mul_rel_r <= 1'b0;
        end else begin
            mem_rel_r <= 1'b0;
            mul_rel_r <= 1'b0;
            case (state_r)
                SEQ_IDLE: begin
                    if (mem_start_s) begin
                        if (MEM_LONG) begin
                            state_r <= SEQ_MEM_WAIT;
                            mcnt_r  <= MEM_LOAD;
                        end else begin
                            mem_rel_r <= 1'b1;
                        end
                    end else if (mul_start_s) begin
                        if (MUL_LONG) begin
                            state_r <= SEQ_MUL_BUSY;
                            xcnt_r  <= MUL_LOAD;
                        end else begin
                            mul_rel_r <= 1'b1;
                        end
                    end else begin
                        state_r <= SEQ_IDLE;
                    end
                end
                SEQ_MEM_WAIT: begin
                    if (mcnt_r <= CNT_ONE) begin
                        state_r   <= SEQ_IDLE;
                        mcnt_r    <= {CW{1'b0}};
                        mem_rel_r <= 1'b1;
                    end else begin
                        mcnt_r <= mcnt_r - CNT_ONE;
                    end
                end
                SEQ_MUL_BUSY: begin
                    if (xcnt_r <= CNT_ONE) begin
                        state_r   <= SEQ_IDLE;
                        xcnt_r    <= {CW{1'b0}};
                        mul_rel_r <= 1'b1;
                    end else begin
                        xcnt_r <= xcnt_r - CNT_ONE;
                    end
                end
                default: begin
                    state_r <= SEQ_IDLE;
                    mcnt_r  <= {CW{1'b0}};
                    xcnt_r  <= {CW{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard and forwarding unit for the five-stage ARM pipeline with N source
// channels, configurable tag width and multi-cycle execute/memory latency.
// Forwarding and load-use detection are combinational; multi-cycle stalls
// come from the stall sequencer and override the ordinary hazard logic.
module hazard_unit_mc
    import hazard_pkg::*;
#(
    parameter int RA_W    = 4,
    parameter int NUM_SRC = 3,
    parameter int MUL_LAT = 3,
    parameter int MEM_LAT = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_SRC*RA_W-1:0]   RaD,
    input  logic [NUM_SRC-1:0]        SrcValidD,
    input  logic [NUM_SRC*RA_W-1:0]   RaE,
    input  logic [NUM_SRC-1:0]        SrcValidE,
    input  logic [RA_W-1:0]           WA3E,
    input  logic [RA_W-1:0]           WA3M,
    input  logic [RA_W-1:0]           WA3W,
    input  logic                      RegWriteE,
    input  logic                      RegWriteM,
    input  logic                      RegWriteW,
    input  logic                      MemtoRegE,
    input  logic                      MulStartE,
    input  logic                      MemReqM,
    input  logic                      PCSrcD,
    input  logic                      PCSrcE,
    input  logic                      PCSrcM,
    input  logic                      PCSrcW,
    input  logic                      BranchTakenE,
    output logic [NUM_SRC*2-1:0]      ForwardE,
    output logic                      StallF,
    output logic                      StallD,
    output logic                      StallE,
    output logic                      StallM,
    output logic                      FlushD,
    output logic                      FlushE,
    output logic                      FlushM,
    output logic                      FlushW
);

    // All-ones tag is the PC, which is never forwarded.
    localparam logic [RA_W-1:0] PC_TAG = {RA_W{1'b1}};

    logic [1:0] fwd_s      [NUM_SRC];
    logic       ld_match_s [NUM_SRC];
    logic       ld_any_s;
    logic       ld_stall_s;
    logic       pc_pend_s;
    logic       mem_busy_s;
    logic       mul_busy_s;

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        logic [RA_W-1:0] tag_e_s;
        logic [RA_W-1:0] tag_d_s;

        assign tag_e_s        = RaE[gi*RA_W +: RA_W];
        assign tag_d_s        = RaD[gi*RA_W +: RA_W];
        assign ld_match_s[gi] = SrcValidD[gi] & (tag_d_s == WA3E);

        // Per-channel forward select: Memory result beats Writeback result.
        always_comb begin
            fwd_s[gi] = FWD_RF;
            if (SrcValidE[gi] && (tag_e_s != PC_TAG)) begin
                if (RegWriteM && (tag_e_s == WA3M)) begin
                    fwd_s[gi] = FWD_MEM;
                end else if (RegWriteW && (tag_e_s == WA3W)) begin
                    fwd_s[gi] = FWD_WB;
                end else begin
                    fwd_s[gi] = FWD_RF;
                end
            end else begin
                fwd_s[gi] = FWD_RF;
            end
        end
    end

    // Pack channel selects and OR-reduce the load-use tag matches.
    always_comb begin
        ForwardE = {(NUM_SRC*2){1'b0}};
        ld_any_s = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            ForwardE[2*i +: 2] = fwd_s[i];
            ld_any_s           = ld_any_s | ld_match_s[i];
        end
    end

    assign ld_stall_s = MemtoRegE & RegWriteE & ld_any_s;
    assign pc_pend_s  = PCSrcD | PCSrcE | PCSrcM;

    stall_seq #(
        .MUL_LAT (MUL_LAT),
        .MEM_LAT (MEM_LAT)
    ) u_stall_seq (
        .clk      (clk),
        .reset    (reset),
        .mem_req  (MemReqM),
        .mul_req  (MulStartE),
        .mem_busy (mem_busy_s),
        .mul_busy (mul_busy_s)
    );

    // Stall/flush select: sequencer stalls mask the single-cycle hazards.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushM = 1'b0;
        FlushW = 1'b0;
        if (!reset) begin
            StallF = 1'b0;
        end else if (mem_busy_s) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else if (mul_busy_s) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            FlushM = 1'b1;
        end else begin
            StallF = ld_stall_s | pc_pend_s;
            StallD = ld_stall_s;
            FlushD = pc_pend_s | PCSrcW | BranchTakenE;
            FlushE = ld_stall_s | BranchTakenE;
        end
    end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Bench for hazard_unit_mc (MUL_LAT=4, MEM_LAT=3): directed steps followed by
// random traffic, each cycle compared against a cycle-count reference model.
module tb_hazard_unit_mc;

    localparam int RA_W    = 4;
    localparam int NUM_SRC = 3;
    localparam int MUL_LAT = 4;
    localparam int MEM_LAT = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [11:0] RaD, RaE;
    logic [2:0]  SrcValidD, SrcValidE;
    logic [3:0]  WA3E, WA3M, WA3W;
    logic        RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MulStartE, MemReqM;
    logic        PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE;
    logic [5:0]  ForwardE;
    logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW;
    logic [7:0]  ctl;

    assign ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW};

    hazard_unit_mc #(
        .RA_W(RA_W), .NUM_SRC(NUM_SRC), .MUL_LAT(MUL_LAT), .MEM_LAT(MEM_LAT)
    ) dut (
        .clk(clk), .reset(reset), .RaD(RaD), .SrcValidD(SrcValidD),
        .RaE(RaE), .SrcValidE(SrcValidE), .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .MulStartE(MulStartE), .MemReqM(MemReqM),
        .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
        .BranchTakenE(BranchTakenE), .ForwardE(ForwardE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: stalled cycles still owed by each kind of sequence.
    int         mem_left = 0;
    int         mul_left = 0;
    bit         mem_rel  = 1'b0;
    bit         mul_rel  = 1'b0;
    bit         m_mem_act, m_mul_act;
    logic [7:0] exp_ctl;
    logic [5:0] exp_fwd;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic model_eval();
        logic [3:0] t;
        bit idle, mem_go, mul_go, ld, pcpend;
        exp_fwd = 6'b0;
        ld = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            t = RaE[i*RA_W +: RA_W];
            if (SrcValidE[i] && t != 4'hF) begin
                if (RegWriteM && t == WA3M)      exp_fwd[2*i +: 2] = 2'b10;
                else if (RegWriteW && t == WA3W) exp_fwd[2*i +: 2] = 2'b01;
            end
            if (SrcValidD[i] && RaD[i*RA_W +: RA_W] == WA3E) ld = 1'b1;
        end
        ld     = ld & MemtoRegE & RegWriteE;
        pcpend = PCSrcD | PCSrcE | PCSrcM;
        idle   = (mem_left == 0) && (mul_left == 0);
        mem_go = idle && MemReqM && (MEM_LAT > 1) && !mem_rel;
        mul_go = idle && MulStartE && (MUL_LAT > 1) && !mul_rel && !mem_go;
        m_mem_act = reset && (mem_left > 0 || mem_go);
        m_mul_act = reset && (mul_left > 0 || mul_go);
        if (!reset)         exp_ctl = 8'h00;
        else if (m_mem_act) exp_ctl = 8'b1111_0001;
        else if (m_mul_act) exp_ctl = 8'b1110_0010;
        else exp_ctl = {ld | pcpend, ld, 2'b00, pcpend | PCSrcW | BranchTakenE,
                        ld | BranchTakenE, 2'b00};
    endtask

    task automatic model_update();
        bit nm, nx;
        nm = 1'b0;
        nx = 1'b0;
        if (!reset) begin
            mem_left = 0; mul_left = 0; mem_rel = 1'b0; mul_rel = 1'b0;
        end else begin
            if (m_mem_act) begin
                mem_left = ((mem_left > 0) ? mem_left : MEM_LAT - 1) - 1;
                nm = (mem_left == 0);
            end
            if (m_mul_act) begin
                mul_left = ((mul_left > 0) ? mul_left : MUL_LAT - 1) - 1;
                nx = (mul_left == 0);
            end
            mem_rel = nm;
            mul_rel = nx;
        end
    endtask

    // One cycle: model comparison plus hand-derived constants.
    task automatic step(input string tag, input logic [7:0] c_ctl, input logic [1:0] c_f0);
        #2;
        model_eval();
        chk({tag, "/fwd"}, {2'b00, ForwardE}, {2'b00, exp_fwd});
        chk({tag, "/ctl"}, ctl, exp_ctl);
        chk({tag, "/ctl_c"}, ctl, c_ctl);
        chk({tag, "/f0_c"}, {6'b0, ForwardE[1:0]}, {6'b0, c_f0});
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic rstep();
        #2;
        model_eval();
        chk("rnd/fwd", {2'b00, ForwardE}, {2'b00, exp_fwd});
        chk("rnd/ctl", ctl, exp_ctl);
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic clear_inputs();
        RaD = 12'h000; RaE = 12'h000; SrcValidD = 3'b000; SrcValidE = 3'b000;
        WA3E = 4'h0; WA3M = 4'h0; WA3W = 4'h0;
        RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
        MemtoRegE = 1'b0; MulStartE = 1'b0; MemReqM = 1'b0;
        PCSrcD = 1'b0; PCSrcE = 1'b0; PCSrcM = 1'b0; PCSrcW = 1'b0;
        BranchTakenE = 1'b0;
    endtask

    function automatic logic [3:0] rtag();
        return ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 5));
    endfunction

    initial begin
        clear_inputs();
        reset = 1'b0;
        @(posedge clk);
        #1;
        MemReqM = 1'b1; MulStartE = 1'b1; BranchTakenE = 1'b1;
        step("reset", 8'h00, 2'b00);
        clear_inputs();
        reset = 1'b1;
        step("idle", 8'h00, 2'b00);

        // forwarding priority
        RaE = 12'h003; SrcValidE = 3'b001; WA3M = 4'd3; WA3W = 4'd3;
        RegWriteM = 1'b1; RegWriteW = 1'b1;
        step("fwd_m", 8'h00, 2'b10);
        RegWriteM = 1'b0;
        step("fwd_w", 8'h00, 2'b01);
        RaE = 12'h00F;
        step("fwd_pc", 8'h00, 2'b00);
        clear_inputs();

        // load-use
        MemtoRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd5; RaD = 12'h500; SrcValidD = 3'b100;
        step("lduse", 8'hC4, 2'b00);
        MemtoRegE = 1'b0;
        step("lduse_done", 8'h00, 2'b00);
        MemtoRegE = 1'b1; SrcValidD = 3'b000;
        step("lduse_inv", 8'h00, 2'b00);
        clear_inputs();

        // multiply
        MulStartE = 1'b1;
        repeat (3) step("mul_busy", 8'hE2, 2'b00);
        step("mul_rel", 8'h00, 2'b00);
        MulStartE = 1'b0;
        step("mul_done", 8'h00, 2'b00);

        // memory wait then multiply
        MemReqM = 1'b1; MulStartE = 1'b1;
        repeat (2) step("mem_wait", 8'hF1, 2'b00);
        step("mem_rel_mul", 8'hE2, 2'b00);
        MemReqM = 1'b0;
        repeat (2) step("mul_after_mem", 8'hE2, 2'b00);
        step("mul_rel2", 8'h00, 2'b00);
        MulStartE = 1'b0;

        // branch idle vs busy
        BranchTakenE = 1'b1;
        step("br_idle", 8'h0C, 2'b00);
        MulStartE = 1'b1;
        repeat (3) step("br_mul", 8'hE2, 2'b00);
        step("br_rel", 8'h0C, 2'b00);
        clear_inputs();
        step("br_done", 8'h00, 2'b00);

        // reset in the 2nd busy cycle of a multiply
        MulStartE = 1'b1;
        step("rm_busy1", 8'hE2, 2'b00);
        #2;
        chk("rm_busy2", ctl, 8'hE2);
        #1;
        reset = 1'b0;
        #1;
        chk("rm_async", ctl, 8'h00);
        model_eval();
        chk("rm_model", ctl, exp_ctl);
        @(posedge clk);
        model_update();
        #1;
        reset = 1'b1;
        repeat (3) step("rm_restart", 8'hE2, 2'b00);
        step("rm_rel", 8'h00, 2'b00);
        clear_inputs();

        // random traffic
        for (int n = 0; n < 400; n++) begin
            RaD = {rtag(), rtag(), rtag()};
            RaE = {rtag(), rtag(), rtag()};
            SrcValidD = 3'($urandom_range(0, 7));
            SrcValidE = 3'($urandom_range(0, 7));
            WA3E = rtag(); WA3M = rtag(); WA3W = rtag();
            RegWriteE = 1'($urandom_range(0, 1));
            RegWriteM = 1'($urandom_range(0, 1));
            RegWriteW = 1'($urandom_range(0, 1));
            MemtoRegE = 1'($urandom_range(0, 1));
            MulStartE = ($urandom_range(0, 3) == 0);
            MemReqM   = ($urandom_range(0, 3) == 0);
            PCSrcD = ($urandom_range(0, 7) == 0);
            PCSrcE = ($urandom_range(0, 7) == 0);
            PCSrcM = ($urandom_range(0, 7) == 0);
            PCSrcW = ($urandom_range(0, 7) == 0);
            BranchTakenE = ($urandom_range(0, 5) == 0);
            reset = ($urandom_range(0, 59) != 0);
            rstep();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
